demux_tdm_2ch: RTL
==================

Name: demux_tdm_2ch

Overview:
- Receiving end of the team's 2:1 channel multiplexing path.
- Takes one serial, time-division-multiplexed bit stream carrying two channels and reassembles each channel's word into its own registered parallel output, with a one-cycle valid strobe per channel.
- A frame-sync input aligns the block; a sync that arrives mid-frame is flagged as an error and the block realigns.
- Sits between the serial link and the per-channel consumers.

Parameters:
- WIDTH, 8, bits per channel word; legal range is WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- D  input  1  serial data bit; LSB of each word first.
- EN  input  1  sample enable; D and SYNC are only observed on edges where EN=1.
- SYNC  input  1  frame start; coincides with bit 0 of channel 0.
- Q0  output  WIDTH  last complete channel-0 word.
- Q1  output  WIDTH  last complete channel-1 word.
- V0  output  1  one-cycle strobe: Q0 updated this cycle.
- V1  output  1  one-cycle strobe: Q1 updated this cycle.
- S  output  1  channel currently being received: 0 in IDLE/CH0, 1 in CH1.
- ERR  output  1  one-cycle strobe: sync arrived mid-frame.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: Q0=0, Q1=0, V0=0, V1=0, S=0, ERR=0, state=IDLE, bit counter=0, shift register=0. Reset takes effect immediately, including mid-frame; the partial word is discarded and no strobe is issued.
- States: IDLE, CH0, CH1. The bit counter is $clog2(WIDTH) bits wide.
- A "sample" is a rising edge with EN=1. Edges with EN=0 hold all state. V0, V1 and ERR are strobes and return to 0 on any edge where they are not set, including EN=0 edges.
- Assembly: on each sample in CH0/CH1, D shifts into the shift register MSB and the register shifts right. After WIDTH samples, bit 0 of the word is the first bit received.
- IDLE:
  - sample with SYNC=1: D becomes bit 0 of channel 0; go to CH0; count=1.
  - sample with SYNC=0: ignored.
- CH0:
  - sample with SYNC=0 and count<WIDTH-1: shift; count+1.
  - sample with SYNC=0 and count=WIDTH-1: Q0 <= completed word and V0=1 on the same edge; go to CH1; count=0.
- CH1:
  - Same as CH0 but counting from 0. At count=WIDTH-1, Q1 <= word and V1=1; go to IDLE.
- Latency: Q0/V0 become visible in the cycle after the edge that samples the last channel-0 bit. Q1/V1 follow the same rule.
- Back-to-back frames: a sample with SYNC=1 on the first sample after the CH1 completion is a legal new frame (IDLE rule). ERR stays 0.
- Mid-frame sync: a sample with SYNC=1 while in CH0 or CH1 sets ERR=1 for one cycle. The partial word is discarded and Q0/Q1 are unchanged. That sample's D becomes bit 0 of a new channel 0; go to CH0; count=1.
- SYNC with EN=0: ignored in every state.
- S is registered and reflects the state after each edge.
- Q0 and Q1 hold their values until their next completion.

Test Plan:
- Reset then one frame, WIDTH=8, EN=1 continuously. Bits 1,0,1,0,0,1,0,1 (SYNC on first) then 0,0,1,1,1,1,0,0 -> Q0=0xA5 with V0 high one cycle after the 8th bit; Q1=0x3C with V1 after the 16th bit; S=1 during bits 9-16; ERR never high.
- Same frame with EN low on alternate cycles -> identical Q0/Q1 values. Strobes are still one cycle wide, and no state advances on EN=0 cycles.
- 20 samples of random D with SYNC=0 from IDLE -> no V0/V1, Q0=Q1=0, S=0.
- Start frame 0xA5/0x3C, then assert SYNC on the 5th bit of channel 1 -> ERR pulse one cycle, Q1 stays at its previous value. The following bits then decode as new frame 0x11/0x22 correctly.
- Two frames back to back (0x01/0x02, then 0xFF/0x80) with SYNC on sample 17 -> V0, V1, V0, V1 pulse in order, final Q0=0xFF, Q1=0x80, ERR=0.
- Drop rst_n mid-way through channel 0, hold two cycles, release, send 0x5A/0xC3 -> all outputs 0 during reset, then Q0=0x5A, Q1=0xC3. No V0 from the aborted frame.

Source files
------------

// File: rtl/demux_tdm_2ch.sv
// Two-channel TDM receiver: deserialises one serial stream into
// per-channel parallel words with valid strobes and a sync error flag.
module demux_tdm_2ch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             D,
  input  logic             EN,
  input  logic             SYNC,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic             V0,
  output logic             V1,
  output logic             S,
  output logic             ERR
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CH0,
    CH1
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [WIDTH-1:0] q0_n, q1_n;
  logic [WIDTH-1:0] word;
  logic             v0_n, v1_n, err_n;
  logic             last;

  assign word = {D, sreg[WIDTH-1:1]};
  assign last = (cnt == CW'(WIDTH-1));
  assign S    = (state == CH1);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sreg_n  = sreg;
    q0_n    = Q0;
    q1_n    = Q1;
    v0_n    = 1'b0;
    v1_n    = 1'b0;
    err_n   = 1'b0;
    if (EN) begin
      unique case (state)
        IDLE: begin
          if (SYNC) begin
            state_n = CH0;
            cnt_n   = CW'(1);
            sreg_n  = word;
          end
        end
        CH0, CH1: begin
          sreg_n = word;
          // a sync inside a frame restarts channel 0 on this bit
          if (SYNC) begin
            err_n   = 1'b1;
            state_n = CH0;
            cnt_n   = CW'(1);
          end else if (last) begin
            cnt_n = '0;
            if (state == CH0) begin
              q0_n    = word;
              v0_n    = 1'b1;
              state_n = CH1;
            end else begin
              q1_n    = word;
              v1_n    = 1'b1;
              state_n = IDLE;
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
      Q0    <= '0;
      Q1    <= '0;
      V0    <= 1'b0;
      V1    <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sreg  <= sreg_n;
      Q0    <= q0_n;
      Q1    <= q1_n;
      V0    <= v0_n;
      V1    <= v1_n;
      ERR   <= err_n;
    end
  end

endmodule
